// File: rtl/invader_formation_ctrl.sv
// invader_formation_ctrl
//
// Purpose:
//   Sequences the invader formation drawn by the colour mapper. Owns the
//   alive map (enemy_status), the formation x offset (enemy_offset) and the
//   sprite frame select (animation_offset). While a wave is running the
//   formation marches one STEP_PX step every `period` frame strobes and turns
//   around at the screen edges. Hit requests from the player-missile logic
//   are resolved here: the addressed invader is cleared and kill/miss is
//   reported one cycle later.
//
// Optional feature (macro SPEEDUP_EN):
//   When defined, the step period shrinks as invaders die:
//   period = 1 + alive_count[5:3], sampled whenever the frame counter reloads.
//   When undefined, period = STEP_FRAMES_BASE always.
//
// Ports:
//   Clk              in   system clock
//   Reset            in   synchronous, active-high reset
//   frame_clk        in   VGA frame strobe (rising edge detected internally)
//   start            in   level; starts a wave from IDLE or CLEARED
//   hit_valid        in   1-cycle hit request
//   hit_col[3:0]     in   hit column 0..9
//   hit_row[2:0]     in   hit row 0..5 (0 = top)
//   hit_ack          out  1-cycle pulse, the cycle after hit_valid
//   hit_kill         out  qualifies hit_ack: 1 = live invader destroyed
//   enemy_status     out  alive bits, [col][row]
//   enemy_offset     out  formation x offset (x of column 0)
//   animation_offset out  sprite frame select, 0 or 8
//   alive_count      out  number of live invaders, 0..60
//   marching_right   out  current march direction
//   cleared          out  high while the wave is cleared
//   state_dbg[1:0]   out  FSM state (0 IDLE, 1 MARCH, 2 CLEARED)
//
// Handshake: hit_valid is a single-cycle request with no back-pressure; every
// cycle with hit_valid high (outside reset) produces exactly one hit_ack on the
// following cycle, with hit_kill valid alongside it.

module invader_formation_ctrl #(
  parameter logic [9:0] START_OFFSET     = 10'd16,
  parameter logic [9:0] STEP_PX          = 10'd4,
  parameter logic [3:0] STEP_FRAMES_BASE = 4'd8,
  parameter logic [9:0] SCREEN_W         = 10'd640
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic            start,
  input  logic            hit_valid,
  input  logic [3:0]      hit_col,
  input  logic [2:0]      hit_row,
  output logic            hit_ack,
  output logic            hit_kill,
  output logic [9:0][5:0] enemy_status,
  output logic [9:0]      enemy_offset,
  output logic [7:0]      animation_offset,
  output logic [5:0]      alive_count,
  output logic            marching_right,
  output logic            cleared,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MARCH   = 2'd1;
  localparam logic [1:0] S_CLEARED = 2'd2;

  localparam logic [5:0] FULL_COUNT = 6'd60;
  localparam logic [7:0] ANIM_ALT   = 8'd8;

  logic [1:0] state;
  logic       frame_clk_q;
  logic [3:0] frame_cnt;
  logic [3:0] period_cur;

`ifdef SPEEDUP_EN
  // Full wave: 1 + 60[5:3] = 8 frames per step.
  localparam logic [3:0] PERIOD_FULL = 4'd1 + {1'b0, FULL_COUNT[5:3]};
  logic [3:0] period_q;
  assign period_cur = period_q;
`else
  assign period_cur = STEP_FRAMES_BASE;
`endif

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic            frame_edge;
  logic            step_fire;
  logic            wave_init;
  logic [3:0]      right_col;
  logic [10:0]     right_reach;
  logic [9:0]      step_offset;
  logic            step_right;
  logic            hit_in_range;
  logic            hit_cell_alive;
  logic            hit_kill_d;
  logic [9:0][5:0] clear_mask;

  assign frame_edge = frame_clk & ~frame_clk_q;

  // A step is suppressed once the last invader is gone so offset and
  // animation freeze on the cycle before the CLEARED transition.
  assign step_fire = (state == S_MARCH) && frame_edge && (alive_count != 6'd0) &&
                     (frame_cnt == (period_cur - 4'd1));

  assign wave_init = start && ((state == S_IDLE) || (state == S_CLEARED));

  // Rightmost column with any live invader; edge check uses pre-hit status.
  always_comb begin
    right_col = 4'd0;
    for (int c = 0; c < 10; c++) begin
      if (|enemy_status[c]) right_col = 4'(c);
    end
  end

  // Right end of the formation after a step: offset + step + R*64 + 32 (sprite width).
  assign right_reach = {1'b0, enemy_offset} + {1'b0, STEP_PX} +
                       {1'b0, right_col, 6'b0} + 11'd32;

  always_comb begin
    step_offset = enemy_offset;
    step_right  = marching_right;
    if (marching_right) begin
      if (right_reach > {1'b0, SCREEN_W}) step_right = 1'b0;
      else                                step_offset = enemy_offset + STEP_PX;
    end else begin
      if ({1'b0, enemy_offset} < {1'b0, STEP_PX}) step_right = 1'b1;
      else                                        step_offset = enemy_offset - STEP_PX;
    end
  end

  // Hit resolution: only a live cell inside the 10x6 grid during MARCH kills.
  assign hit_in_range = (hit_col <= 4'd9) && (hit_row <= 3'd5);

  always_comb begin
    hit_cell_alive = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < 6; r++) begin
        if ((hit_col == 4'(c)) && (hit_row == 3'(r))) hit_cell_alive = enemy_status[c][r];
      end
    end
  end

  assign hit_kill_d = hit_valid && (state == S_MARCH) && hit_in_range && hit_cell_alive;

  always_comb begin
    clear_mask = '0;
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < 6; r++) begin
        if (hit_kill_d && (hit_col == 4'(c)) && (hit_row == 3'(r))) clear_mask[c][r] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= S_IDLE;
      frame_clk_q      <= 1'b0;
      frame_cnt        <= 4'd0;
      enemy_status     <= '1;
      alive_count      <= FULL_COUNT;
      enemy_offset     <= START_OFFSET;
      animation_offset <= 8'd0;
      marching_right   <= 1'b1;
      hit_ack          <= 1'b0;
      hit_kill         <= 1'b0;
`ifdef SPEEDUP_EN
      period_q         <= PERIOD_FULL;
`endif
    end else begin
      frame_clk_q <= frame_clk;
      hit_ack     <= hit_valid;
      hit_kill    <= hit_kill_d;

      // Hit and step may land on the same edge; both take effect.
      enemy_status <= enemy_status & ~clear_mask;
      if (hit_kill_d) alive_count <= alive_count - 6'd1;

      case (state)
        S_MARCH: begin
          if (alive_count == 6'd0) begin
            state <= S_CLEARED;
          end else if (step_fire) begin
            frame_cnt        <= 4'd0;
            enemy_offset     <= step_offset;
            marching_right   <= step_right;
            animation_offset <= (animation_offset == 8'd0) ? ANIM_ALT : 8'd0;
`ifdef SPEEDUP_EN
            period_q         <= 4'd1 + {1'b0, alive_count[5:3]};
`endif
          end else if (frame_edge) begin
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        S_IDLE, S_CLEARED: begin
          if (wave_init) begin
            state            <= S_MARCH;
            frame_cnt        <= 4'd0;
            enemy_status     <= '1;
            alive_count      <= FULL_COUNT;
            enemy_offset     <= START_OFFSET;
            animation_offset <= 8'd0;
            marching_right   <= 1'b1;
`ifdef SPEEDUP_EN
            period_q         <= PERIOD_FULL;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cleared   = (state == S_CLEARED);
  assign state_dbg = state;

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Bench for invader_formation_ctrl (default build: fixed 8-frame step period).
// Hit outcomes go through an expected queue; everything else is checked
// against directed constants derived from the formation geometry.

module tb_invader_formation_ctrl;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            frame_clk;
  logic            start;
  logic            hit_valid;
  logic [3:0]      hit_col;
  logic [2:0]      hit_row;
  logic            hit_ack;
  logic            hit_kill;
  logic [9:0][5:0] enemy_status;
  logic [9:0]      enemy_offset;
  logic [7:0]      animation_offset;
  logic [5:0]      alive_count;
  logic            marching_right;
  logic            cleared;
  logic [1:0]      state_dbg;

  localparam logic [63:0] ALL_ALIVE = 64'h0FFF_FFFF_FFFF_FFFF;

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  invader_formation_ctrl dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .start            (start),
    .hit_valid        (hit_valid),
    .hit_col          (hit_col),
    .hit_row          (hit_row),
    .hit_ack          (hit_ack),
    .hit_kill         (hit_kill),
    .enemy_status     (enemy_status),
    .enemy_offset     (enemy_offset),
    .animation_offset (animation_offset),
    .alive_count      (alive_count),
    .marching_right   (marching_right),
    .cleared          (cleared),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected kill flag.
  always @(negedge Clk) begin
    if (hit_ack === 1'b1) begin
      chk("ack_has_request", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("hit_kill", 64'(hit_kill), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n * 8) frame_pulse();
  endtask

  task automatic do_hit(input int c, input int r, input logic k);
    @(negedge Clk);
    hit_col = 4'(c); hit_row = 3'(r); hit_valid = 1'b1;
    exp_q.push_back(k);
    @(negedge Clk);
    hit_valid = 1'b0;
    #1 chk("ack_latency", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge Clk) start = 1'b1;
    @(negedge Clk) start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
    hit_valid = 1'b0; hit_col = 4'd0; hit_row = 3'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_state", 64'(state_dbg), 64'd0);
    chk("rst_status", 64'(enemy_status), ALL_ALIVE);
    chk("rst_alive", 64'(alive_count), 64'd60);
    chk("rst_offset", 64'(enemy_offset), 64'd16);
    chk("rst_anim", 64'(animation_offset), 64'd0);
    chk("rst_dir", 64'(marching_right), 64'd1);
    chk("rst_ack", 64'(hit_ack), 64'd0);
    chk("rst_cleared", 64'(cleared), 64'd0);

    pulse_start();
    chk("start_march", 64'(state_dbg), 64'd1);

    // First step only after 8 frame edges.
    repeat (7) frame_pulse();
    chk("pre_step_offset", 64'(enemy_offset), 64'd16);
    frame_pulse();
    chk("step1_offset", 64'(enemy_offset), 64'd20);
    chk("step1_anim", 64'(animation_offset), 64'd8);

    // Right edge with column 9 alive: limit offset 32.
    steps(3);
    chk("step4_offset", 64'(enemy_offset), 64'd32);
    chk("step4_anim", 64'(animation_offset), 64'd0);
    steps(1);
    chk("rev_dir", 64'(marching_right), 64'd0);
    chk("rev_offset", 64'(enemy_offset), 64'd32);
    chk("rev_anim", 64'(animation_offset), 64'd8);
    steps(1);
    chk("left_offset", 64'(enemy_offset), 64'd28);

    // Single hit, then the same cell again.
    do_hit(3, 2, 1'b1);
    chk("hit_status", 64'(enemy_status[3][2]), 64'd0);
    chk("hit_alive", 64'(alive_count), 64'd59);
    do_hit(3, 2, 1'b0);
    chk("rehit_alive", 64'(alive_count), 64'd59);

    // Back-to-back hits on one cell: kill then miss.
    @(negedge Clk);
    hit_col = 4'd0; hit_row = 3'd0; hit_valid = 1'b1; exp_q.push_back(1'b1);
    @(negedge Clk);
    exp_q.push_back(1'b0);
    @(negedge Clk);
    hit_valid = 1'b0;
    #1 chk("b2b_drain", 64'(exp_q.size()), 64'd0);
    chk("b2b_alive", 64'(alive_count), 64'd58);

    // Out-of-range column.
    do_hit(12, 0, 1'b0);
    chk("oor_alive", 64'(alive_count), 64'd58);

    // Hit on the step edge: both take effect.
    repeat (7) frame_pulse();
    @(negedge Clk);
    frame_clk = 1'b1; hit_col = 4'd5; hit_row = 3'd5; hit_valid = 1'b1; exp_q.push_back(1'b1);
    @(negedge Clk);
    frame_clk = 1'b0; hit_valid = 1'b0;
    #1 chk("stephit_ack", 64'(exp_q.size()), 64'd0);
    chk("stephit_offset", 64'(enemy_offset), 64'd24);
    chk("stephit_anim", 64'(animation_offset), 64'd8);
    chk("stephit_status", 64'(enemy_status[5][5]), 64'd0);
    chk("stephit_alive", 64'(alive_count), 64'd57);

    // Kill column 9; march to left edge, then right to the widened limit.
    for (int r = 0; r < 6; r++) do_hit(9, r, 1'b1);
    chk("col9_alive", 64'(alive_count), 64'd51);
    steps(6);
    chk("left_edge_offset", 64'(enemy_offset), 64'd0);
    steps(1);
    chk("left_rev_dir", 64'(marching_right), 64'd1);
    chk("left_rev_offset", 64'(enemy_offset), 64'd0);
    steps(24);
    chk("wide_offset", 64'(enemy_offset), 64'd96);
    chk("wide_dir", 64'(marching_right), 64'd1);
    steps(1);
    chk("wide_rev_dir", 64'(marching_right), 64'd0);
    chk("wide_rev_offset", 64'(enemy_offset), 64'd96);

    // Reset mid-wave with a hit pending: no ack, reset values.
    @(negedge Clk);
    Reset = 1'b1; hit_col = 4'd1; hit_row = 3'd1; hit_valid = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; hit_valid = 1'b0;
    chk("mrst_ack", 64'(hit_ack), 64'd0);
    chk("mrst_state", 64'(state_dbg), 64'd0);
    chk("mrst_status", 64'(enemy_status), ALL_ALIVE);
    chk("mrst_alive", 64'(alive_count), 64'd60);
    chk("mrst_offset", 64'(enemy_offset), 64'd16);
    chk("mrst_dir", 64'(marching_right), 64'd1);
    chk("mrst_anim", 64'(animation_offset), 64'd0);

    // Hit while IDLE is acknowledged as a miss.
    do_hit(2, 2, 1'b0);
    chk("idle_status", 64'(enemy_status), ALL_ALIVE);

    // start during MARCH must not restart the frame count.
    pulse_start();
    repeat (4) frame_pulse();
    pulse_start();
    repeat (4) frame_pulse();
    chk("start_ignored_offset", 64'(enemy_offset), 64'd20);
    chk("start_ignored_anim", 64'(animation_offset), 64'd8);

    // Kill everything.
    for (int c = 0; c < 10; c++)
      for (int r = 0; r < 6; r++) do_hit(c, r, 1'b1);
    chk("all_dead_alive", 64'(alive_count), 64'd0);
    @(negedge Clk);
    chk("cleared_flag", 64'(cleared), 64'd1);
    chk("cleared_state", 64'(state_dbg), 64'd2);
    repeat (20) frame_pulse();
    chk("frozen_offset", 64'(enemy_offset), 64'd20);
    chk("frozen_anim", 64'(animation_offset), 64'd8);
    do_hit(0, 0, 1'b0);

    // Restart from CLEARED: full re-init.
    pulse_start();
    chk("restart_state", 64'(state_dbg), 64'd1);
    chk("restart_cleared", 64'(cleared), 64'd0);
    chk("restart_status", 64'(enemy_status), ALL_ALIVE);
    chk("restart_alive", 64'(alive_count), 64'd60);
    chk("restart_offset", 64'(enemy_offset), 64'd16);
    chk("restart_anim", 64'(animation_offset), 64'd0);
    chk("restart_dir", 64'(marching_right), 64'd1);

    // ---------------- report ----------------
    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
